luislt_issue_arbiter: RTL and testbench

//  Shares one LuiSlt functional unit among NUM_REQ reservation stations in the dynamic pipeline.

---
 rtl/luislt_issue_arbiter.sv | 150 +++++++++++++++
 tb/tb_luislt_issue_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/luislt_issue_arbiter.sv
// Round-robin issue arbiter in front of a shared LuiSlt unit: S1 holds the granted
// operands, S2 holds the captured result until the CDB accepts it.

module luislt_issue_lane #(
    parameter int W = 8
) (
    input  logic         gnt,
    input  logic [W-1:0] op,
    output logic [W-1:0] sel
);
    assign sel = gnt ? op : '0;
endmodule

module luislt_issue_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0][1:0]         req_aluc,
    input  logic [NUM_REQ-1:0][31:0]        req_a,
    input  logic [NUM_REQ-1:0][31:0]        req_b,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag,
    output logic [31:0]                     fu_a,
    output logic [31:0]                     fu_b,
    output logic [1:0]                      fu_aluc,
    input  logic [31:0]                     fu_r,
    input  logic                            fu_is_equal,
    input  logic                            fu_is_smaller,
    output logic                            cdb_valid,
    input  logic                            cdb_ready,
    output logic [TAG_W-1:0]                cdb_tag,
    output logic [31:0]                     cdb_data,
    output logic [1:0]                      cdb_flags,
    output logic                            busy,
    output logic [CNT_W-1:0]                issue_cnt
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [1:0]       aluc;
        logic [TAG_W-1:0] tag;
    } op_t;

    localparam int OP_W = $bits(op_t);

    logic                          s1_v, s2_v;
    op_t                           s1_op;
    logic [31:0]                   s2_data;
    logic [1:0]                    s2_flags;
    logic [TAG_W-1:0]              s2_tag;
    logic [PTR_W-1:0]              rr_ptr;

    logic                          s2_free, s1_adv, s1_free;
    logic                          found, xfer;
    logic [PTR_W-1:0]              cand, gnt_idx, nxt_ptr;
    logic [NUM_REQ-1:0][OP_W-1:0]  lane_sel;
    logic [OP_W-1:0]               sel_flat;
    op_t                           sel_op;

    assign s2_free = !s2_v | cdb_ready;
    assign s1_adv  = s1_v & s2_free;
    assign s1_free = !s1_v | s1_adv;

    // First valid station at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // rst_n gating keeps req_ready low throughout reset even while stations are valid.
    assign req_ready = (found && s1_free && !flush && rst_n) ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign xfer      = |req_ready;
    assign nxt_ptr   = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            luislt_issue_lane #(.W(OP_W)) u_lane (
                .gnt (req_ready[gi]),
                .op  ({req_a[gi], req_b[gi], req_aluc[gi], req_tag[gi]}),
                .sel (lane_sel[gi])
            );
        end
    endgenerate

    always_comb begin
        sel_flat = '0;
        for (int k = 0; k < NUM_REQ; k++) sel_flat = sel_flat | lane_sel[k];
    end
    assign sel_op = op_t'(sel_flat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            s1_op     <= '0;
            s2_data   <= '0;
            s2_flags  <= '0;
            s2_tag    <= '0;
            rr_ptr    <= '0;
            issue_cnt <= '0;
        end else if (flush) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            if (xfer) begin
                s1_op     <= sel_op;
                s1_v      <= 1'b1;
                rr_ptr    <= nxt_ptr;
                issue_cnt <= issue_cnt + CNT_W'(1);
            end else if (s1_adv) begin
                s1_v <= 1'b0;
            end
            // S2 only reloads when free, so the CDB payload holds under backpressure.
            if (s1_adv) begin
                s2_data  <= fu_r;
                s2_flags <= {fu_is_equal, fu_is_smaller};
                s2_tag   <= s1_op.tag;
                s2_v     <= 1'b1;
            end else if (s2_v && cdb_ready) begin
                s2_v <= 1'b0;
            end
        end
    end

    assign fu_a      = s1_op.a;
    assign fu_b      = s1_op.b;
    assign fu_aluc   = s1_op.aluc;
    assign cdb_valid = s2_v;
    assign cdb_tag   = s2_tag;
    assign cdb_data  = s2_data;
    assign cdb_flags = s2_flags;
    assign busy      = s1_v | s2_v;

endmodule

// File: tb/tb_luislt_issue_arbiter.sv
// Directed bench for luislt_issue_arbiter with a behavioural LuiSlt unit on the fu_* side.

module tb_luislt_issue_arbiter;
    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 4;
    localparam int CNT_W   = 16;

    logic                          clk = 1'b0;
    logic                          rst_n, flush, cdb_ready;
    logic [NUM_REQ-1:0]            req_valid, req_ready;
    logic [NUM_REQ-1:0][1:0]       req_aluc;
    logic [NUM_REQ-1:0][31:0]      req_a, req_b;
    logic [NUM_REQ-1:0][TAG_W-1:0] req_tag;
    logic [31:0]                   fu_a, fu_b, fu_r, cdb_data;
    logic [1:0]                    fu_aluc, cdb_flags;
    logic                          fu_is_equal, fu_is_smaller, cdb_valid, busy;
    logic [TAG_W-1:0]              cdb_tag;
    logic [CNT_W-1:0]              issue_cnt;

    int npass = 0;
    int nfail = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    luislt_issue_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_aluc(req_aluc),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .fu_a(fu_a), .fu_b(fu_b), .fu_aluc(fu_aluc), .fu_r(fu_r),
        .fu_is_equal(fu_is_equal), .fu_is_smaller(fu_is_smaller),
        .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_flags(cdb_flags), .busy(busy), .issue_cnt(issue_cnt)
    );

    // Shared LuiSlt unit: 1x = slt/sltu (bit0 signed), 0x = lui of b[15:0].
    always_comb begin
        fu_is_equal   = (fu_a == fu_b);
        fu_is_smaller = (fu_a < fu_b);
        if (fu_aluc[1])
            fu_r = {31'b0, fu_aluc[0] ? ($signed(fu_a) < $signed(fu_b)) : (fu_a < fu_b)};
        else
            fu_r = {fu_b[15:0], 16'h0000};
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int i, input logic [1:0] aluc, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] tag);
        req_aluc[i] = aluc;
        req_a[i]    = a;
        req_b[i]    = b;
        req_tag[i]  = tag;
    endtask

    // Hand-computed results of the four stations' standard ops.
    int               order [6] = '{0, 1, 2, 3, 0, 1};
    logic [31:0]      ed    [4] = '{32'h0010_0000, 32'h1, 32'h1, 32'h0};
    logic [1:0]       ef    [4] = '{2'b01, 2'b01, 2'b00, 2'b10};
    logic [TAG_W-1:0] et    [4] = '{4'h0, 4'h1, 4'h2, 4'hA};

    task automatic load_std();
        load(0, 2'b00, 32'h0,         32'h0000_0010, 4'h0);
        load(1, 2'b10, 32'h5,         32'h7,         4'h1);
        load(2, 2'b11, 32'h8000_0000, 32'h0,         4'h2);
        load(3, 2'b10, 32'h9,         32'h9,         4'hA);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; cdb_ready = 1'b1; req_valid = '1;
        req_aluc = '0; req_a = '0; req_b = '0; req_tag = '0;
        #2;
        chk("rst_cdb_valid", cdb_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", issue_cnt, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_fu_a", fu_a, 0);
        rst_n = 1'b1; req_valid = '0;

        // Single signed slt: -1 < 1
        load(0, 2'b11, 32'hFFFF_FFFF, 32'h1, 4'h3);
        req_valid = 4'b0001; #1;
        chk("t1_grant", req_ready, 4'b0001);
        step(); req_valid = '0;
        chk("t1_busy", busy, 1);
        chk("t1_cdb_early", cdb_valid, 0);
        chk("t1_fu_a", fu_a, 32'hFFFF_FFFF);
        chk("t1_fu_aluc", fu_aluc, 2'b11);
        chk("t1_cnt", issue_cnt, 1);
        step();
        chk("t1_cdb_valid", cdb_valid, 1);
        chk("t1_data", cdb_data, 1);
        chk("t1_tag", cdb_tag, 4'h3);
        chk("t1_flags", cdb_flags, 2'b00);
        step();
        chk("t1_drain_valid", cdb_valid, 0);
        chk("t1_drain_busy", busy, 0);

        // Flush with S1 and S2 both valid
        load_std();
        req_valid = 4'b0010; step();
        req_valid = 4'b0100; step();
        flush = 1'b1; cdb_ready = 1'b0; req_valid = 4'b1111; #1;
        chk("t5_no_grant", req_ready, 0);
        chk("t5_busy_pre", busy, 1);
        chk("t5_cdb_pre", cdb_valid, 1);
        step(); flush = 1'b0; cdb_ready = 1'b1;
        chk("t5_cdb_post", cdb_valid, 0);
        chk("t5_busy_post", busy, 0);
        chk("t5_cnt_held", issue_cnt, 3);
        #1;
        chk("t5_ptr_held", req_ready, 4'b1000);

        // Only st2 valid while rr_ptr=3: wrap search picks st2, pointer lands on 3
        req_valid = 4'b0100; #1;
        chk("t4_wrap_grant", req_ready, 4'b0100);
        step(); req_valid = 4'b1111; #1;
        chk("t4_ptr_after", req_ready, 4'b1000);
        req_valid = '0;
        step();
        chk("t4_cdb_tag", cdb_tag, 4'h2);
        chk("t4_cdb_data", cdb_data, 1);
        chk("t4_cnt", issue_cnt, 4);

        // Async reset between edges with S1 and S2 loaded
        cdb_ready = 1'b0; req_valid = 4'b0001;
        step();
        chk("t6_busy_pre", busy, 1);
        chk("t6_cnt_pre", issue_cnt, 5);
        #2; rst_n = 1'b0; #1;
        chk("t6_cdb_valid", cdb_valid, 0);
        chk("t6_cnt", issue_cnt, 0);
        chk("t6_busy", busy, 0);
        chk("t6_req_ready", req_ready, 0);
        #3; rst_n = 1'b1;

        // All stations valid, full throughput from reset
        cdb_ready = 1'b1; req_valid = 4'b1111; #1;
        chk("t2_first_grant", req_ready, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t2_grant", req_ready, 4'b0001 << order[k+1]);
            if (k >= 1) begin
                chk("t2_cdb_valid", cdb_valid, 1);
                chk("t2_cdb_tag", cdb_tag, et[order[k-1]]);
                chk("t2_cdb_data", cdb_data, ed[order[k-1]]);
                chk("t2_cdb_flags", cdb_flags, ef[order[k-1]]);
            end
        end
        chk("t2_cnt", issue_cnt, 5);
        req_valid = '0;
        step();
        chk("t2_last_tag", cdb_tag, et[0]);
        chk("t2_last_data", cdb_data, ed[0]);
        step();
        chk("t2_drain", busy, 0);

        // lui held under 3 cycles of CDB backpressure
        load(1, 2'b00, 32'h0, 32'h0000_1234, 4'h5);
        req_valid = 4'b0010; #1;
        chk("t3_grant_lui", req_ready, 4'b0010);
        step();
        load(2, 2'b10, 32'h5, 32'h7, 4'h6);
        req_valid = 4'b0100; cdb_ready = 1'b0; #1;
        chk("t3_grant_s2", req_ready, 4'b0100);
        step();
        load(3, 2'b11, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 4'h7);
        req_valid = 4'b1000; #1;
        chk("t3_full", req_ready, 0);
        chk("t3_valid", cdb_valid, 1);
        chk("t3_data", cdb_data, 32'h1234_0000);
        chk("t3_tag", cdb_tag, 4'h5);
        chk("t3_cnt", issue_cnt, 7);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("t3_hold_data", cdb_data, 32'h1234_0000);
            chk("t3_hold_tag", cdb_tag, 4'h5);
            chk("t3_hold_full", req_ready, 0);
        end
        cdb_ready = 1'b1; #1;
        chk("t3_release", req_ready, 4'b1000);
        step(); req_valid = '0;
        chk("t3_next_tag", cdb_tag, 4'h6);
        chk("t3_next_data", cdb_data, 1);
        chk("t3_next_flags", cdb_flags, 2'b01);
        chk("t3_cnt_end", issue_cnt, 8);
        step();
        chk("t3_last_tag", cdb_tag, 4'h7);
        chk("t3_last_data", cdb_data, 1);
        chk("t3_last_flags", cdb_flags, 2'b01);
        step();
        chk("t3_drain_valid", cdb_valid, 0);
        chk("t3_drain_busy", busy, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
